// File: rtl/z80_bus_pkg.sv
// Shared types and defaults for the Z80 bus arbiter and its round-robin picker.
package z80_bus_pkg;

  localparam int unsigned NREQ_DEF     = 2;
  localparam int unsigned MAX_HOLD_DEF = 256;
  localparam int unsigned CPU_GAP_DEF  = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQUEST = 3'd1,
    GRANTED = 3'd2,
    RELEASE = 3'd3,
    GAP     = 3'd4
  } arb_state_t;

  // Index width for an n-entry vector; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/z80_rr_pick.sv
// Combinational round-robin picker: first set request at or after (last+1) mod NREQ.
module z80_rr_pick
  import z80_bus_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned IW   = idx_w(NREQ_DEF)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] pick,
  output logic [IW-1:0]   pick_idx,
  output logic            any
);

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      int unsigned idx;
      idx = (32'(last) + k) % NREQ;
      if (!any && req[IW'(idx)]) begin
        any              = 1'b1;
        pick[IW'(idx)]   = 1'b1;
        pick_idx         = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/z80_bus_arbiter.sv
// Shares the Z80 bus between the CPU and NREQ requesters via nBUSRQ/nBUSACK,
// with round-robin fairness, a per-tenure hold limit and a guaranteed CPU gap.
module z80_bus_arbiter
  import z80_bus_pkg::*;
#(
  parameter int unsigned NREQ     = NREQ_DEF,
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF,
  parameter int unsigned CPU_GAP  = CPU_GAP_DEF
) (
  input  logic            CLK,
  input  logic            nRESET,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic            bus_own,
  output logic            timeout,
  output logic            nBUSRQ,
  input  logic            nBUSACK
);

  localparam int unsigned IW = idx_w(NREQ);
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam int unsigned GW = (CPU_GAP > 0) ? $clog2(CPU_GAP + 1) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [GW-1:0] GAP_LAST = GW'((CPU_GAP > 0) ? CPU_GAP - 1 : 0);

  arb_state_t      r_state, w_state_nx;
  logic [NREQ-1:0] r_grant, w_grant_nx;
  logic            r_bus_own;
  logic            r_timeout, w_timeout_nx;
  logic            r_nbusrq, w_nbusrq_nx;
  logic [IW-1:0]   r_last, w_last_nx;
  logic [HW-1:0]   r_hold, w_hold_nx;
  logic [GW-1:0]   r_gap, w_gap_nx;

  logic [NREQ-1:0] w_pick;
  logic [IW-1:0]   w_pick_idx;
  logic            w_any;
  logic            w_owner_req;

  z80_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req      (req),
    .last     (r_last),
    .pick     (w_pick),
    .pick_idx (w_pick_idx),
    .any      (w_any)
  );

  assign w_owner_req = |(req & r_grant);

  // Next-state and next-output logic; everything below is registered.
  always_comb begin
    w_state_nx   = r_state;
    w_grant_nx   = r_grant;
    w_timeout_nx = 1'b0;
    w_nbusrq_nx  = r_nbusrq;
    w_last_nx    = r_last;
    w_hold_nx    = r_hold;
    w_gap_nx     = r_gap;

    case (r_state)
      IDLE: begin
        w_grant_nx  = '0;
        w_nbusrq_nx = 1'b1;
        if (|req) begin
          w_state_nx  = REQUEST;
          w_nbusrq_nx = 1'b0;
        end
      end
      REQUEST: begin
        if (!nBUSACK) begin
          if (w_any) begin
            w_state_nx = GRANTED;
            w_grant_nx = w_pick;
            w_last_nx  = w_pick_idx;
            w_hold_nx  = HW'(1);
          end else begin
            w_state_nx  = RELEASE;
            w_nbusrq_nx = 1'b1;
          end
        end
      end
      GRANTED: begin
        // A voluntary release wins over a timeout landing on the same edge.
        if (!w_owner_req) begin
          w_state_nx  = RELEASE;
          w_grant_nx  = '0;
          w_nbusrq_nx = 1'b1;
        end else if (r_hold == HOLD_MAX) begin
          w_state_nx   = RELEASE;
          w_grant_nx   = '0;
          w_nbusrq_nx  = 1'b1;
          w_timeout_nx = 1'b1;
        end else begin
          w_hold_nx = r_hold + HW'(1);
        end
      end
      RELEASE: begin
        if (nBUSACK) begin
          w_hold_nx = '0;
          w_gap_nx  = '0;
          w_state_nx = (CPU_GAP > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (r_gap == GAP_LAST) begin
          w_state_nx = IDLE;
          w_gap_nx   = '0;
        end else begin
          w_gap_nx = r_gap + GW'(1);
        end
      end
      default: begin
        w_state_nx  = IDLE;
        w_grant_nx  = '0;
        w_nbusrq_nx = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_bus_own <= 1'b0;
      r_timeout <= 1'b0;
      r_nbusrq  <= 1'b1;
      r_last    <= IW'(NREQ - 1);
      r_hold    <= '0;
      r_gap     <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_grant   <= w_grant_nx;
      r_bus_own <= |w_grant_nx;
      r_timeout <= w_timeout_nx;
      r_nbusrq  <= w_nbusrq_nx;
      r_last    <= w_last_nx;
      r_hold    <= w_hold_nx;
      r_gap     <= w_gap_nx;
    end
  end

  assign grant   = r_grant;
  assign bus_own = r_bus_own;
  assign timeout = r_timeout;
  assign nBUSRQ  = r_nbusrq;

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Bench for z80_bus_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a tenure-level model of the arbitration rules.
module tb_z80_bus_arbiter;

  localparam int NREQ     = 2;
  localparam int MAX_HOLD = 8;
  localparam int CPU_GAP  = 4;

  logic            CLK = 1'b0;
  logic            nRESET;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] grant;
  logic            bus_own;
  logic            timeout;
  logic            nBUSRQ;
  logic            nBUSACK;

  z80_bus_arbiter #(
    .NREQ     (NREQ),
    .MAX_HOLD (MAX_HOLD),
    .CPU_GAP  (CPU_GAP)
  ) dut (
    .CLK     (CLK),
    .nRESET  (nRESET),
    .req     (req),
    .grant   (grant),
    .bus_own (bus_own),
    .timeout (timeout),
    .nBUSRQ  (nBUSRQ),
    .nBUSACK (nBUSACK)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: who owns the bus, whether the CPU is being asked, and how much
  // gap remains before new requests are looked at.
  bit m_asking;
  bit m_wait_rel;
  int m_owner;
  int m_held;
  int m_gap_left;
  int m_last;
  bit m_to;

  bit cpu_auto = 1'b0;
  int cpu_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_asking   = 1'b0;
    m_wait_rel = 1'b0;
    m_owner    = -1;
    m_held     = 0;
    m_gap_left = 0;
    m_last     = NREQ - 1;
    m_to       = 1'b0;
  endtask

  task automatic model_end_tenure();
    m_owner    = -1;
    m_asking   = 1'b0;
    m_wait_rel = 1'b1;
  endtask

  task automatic model_edge(input logic [NREQ-1:0] r, input logic ack);
    bit found;
    int idx;
    m_to = 1'b0;
    if (m_gap_left > 0) begin
      m_gap_left--;
    end else if (m_wait_rel) begin
      if (ack) begin
        m_wait_rel = 1'b0;
        m_gap_left = CPU_GAP;
      end
    end else if (m_owner >= 0) begin
      if (!r[m_owner]) model_end_tenure();
      else if (m_held == MAX_HOLD) begin
        model_end_tenure();
        m_to = 1'b1;
      end else m_held++;
    end else if (m_asking) begin
      if (!ack) begin
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
          idx = (m_last + k) % NREQ;
          if (!found && r[idx]) begin
            found   = 1'b1;
            m_owner = idx;
            m_last  = idx;
            m_held  = 1;
          end
        end
        if (!found) model_end_tenure();
      end
    end else if (r != '0) begin
      m_asking = 1'b1;
    end
  endtask

  // One clock: advance model on the edge, compare just after it, then let the CPU react.
  task automatic step();
    logic [NREQ-1:0] r_s;
    logic            a_s;
    logic [31:0]     exp_grant;
    r_s = req;
    a_s = nBUSACK;
    @(posedge CLK);
    model_edge(r_s, a_s);
    #1;
    exp_grant = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    chk("grant", 32'(grant), exp_grant);
    chk("bus_own", 32'(bus_own), 32'(m_owner >= 0));
    chk("timeout", 32'(timeout), 32'(m_to));
    chk("nBUSRQ", 32'(nBUSRQ), 32'(!m_asking));
    chk("own_vs_ack", 32'(bus_own & nBUSACK), 32'd0);
    if (cpu_auto && (nBUSRQ !== nBUSACK)) begin
      if (cpu_cnt > 0) cpu_cnt--;
      else begin
        nBUSACK = nBUSRQ;
        cpu_cnt = $urandom_range(0, 6);
      end
    end
  endtask

  task automatic gap_to_idle();
    nBUSACK = 1'b1;
    step();
    repeat (CPU_GAP) step();
  endtask

  initial begin
    int hold_cycles;
    int to_pulses;

    nRESET  = 1'b0;
    req     = '0;
    nBUSACK = 1'b1;
    model_reset();
    #12;
    chk("rst_nBUSRQ", 32'(nBUSRQ), 32'd1);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_bus_own", 32'(bus_own), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    @(negedge CLK);
    nRESET = 1'b1;
    step();

    // Single request, ack three cycles later, then voluntary drop.
    req = 2'b01;
    step();
    chk("req_to_busrq", 32'(nBUSRQ), 32'd0);
    repeat (3) step();
    nBUSACK = 1'b0;
    step();
    chk("first_grant", 32'(grant), 32'h1);
    repeat (2) step();
    req = 2'b00;
    step();
    chk("drop_grant", 32'(grant), 32'd0);
    chk("drop_busrq", 32'(nBUSRQ), 32'd1);

    // Slow release: CPU keeps nBUSACK low; a request during the gap is ignored.
    repeat (10) step();
    nBUSACK = 1'b1;
    req     = 2'b01;
    step();
    for (int i = 0; i < CPU_GAP; i++) begin
      step();
      chk("gap_holds_busrq", 32'(nBUSRQ), 32'd1);
    end
    step();
    chk("gap_end_busrq", 32'(nBUSRQ), 32'd0);

    // Slow ack: 20 cycles in REQUEST with no grant.
    for (int i = 0; i < 20; i++) begin
      step();
      chk("slow_ack_nogrant", 32'(grant), 32'd0);
    end
    nBUSACK = 1'b0;
    step();
    chk("second_grant", 32'(grant), 32'h1);

    // Timeout: requester 0 holds, requester 1 arrives but cannot preempt.
    req         = 2'b11;
    hold_cycles = 1;
    to_pulses   = 0;
    for (int i = 0; i < 30 && grant != '0; i++) begin
      step();
      if (grant != '0) hold_cycles++;
      if (timeout) to_pulses++;
    end
    chk("hold_cycles", 32'(hold_cycles), 32'd8);
    chk("timeout_pulses", 32'(to_pulses), 32'd1);
    gap_to_idle();
    step();
    nBUSACK = 1'b0;
    step();
    chk("rr_after_timeout", 32'(grant), 32'h2);
    repeat (2) step();
    req = 2'b01;
    step();
    gap_to_idle();
    step();
    nBUSACK = 1'b0;
    step();
    chk("rr_back_to_0", 32'(grant), 32'h1);
    req = 2'b00;
    step();
    gap_to_idle();

    // Abandoned request: req drops before the ack arrives.
    req = 2'b01;
    repeat (2) step();
    req = 2'b00;
    step();
    nBUSACK = 1'b0;
    step();
    chk("abandon_grant", 32'(grant), 32'd0);
    chk("abandon_busrq", 32'(nBUSRQ), 32'd1);
    repeat (3) step();
    gap_to_idle();

    // Reset in the middle of a tenure.
    req = 2'b01;
    step();
    nBUSACK = 1'b0;
    step();
    chk("pre_reset_grant", 32'(grant), 32'h1);
    step();
    #2;
    nRESET = 1'b0;
    #1;
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_bus_own", 32'(bus_own), 32'd0);
    chk("midrst_nBUSRQ", 32'(nBUSRQ), 32'd1);
    chk("midrst_timeout", 32'(timeout), 32'd0);
    model_reset();
    nBUSACK = 1'b1;
    req     = '0;
    @(negedge CLK);
    nRESET = 1'b1;

    // Random traffic with a CPU that acks and releases after random delays.
    cpu_auto = 1'b1;
    cpu_cnt  = 0;
    repeat (4000) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i]) begin
          if ($urandom_range(0, 11) == 0) req[i] = 1'b0;
        end else if (req[i]) begin
          if ($urandom_range(0, 29) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 5) == 0) begin
          req[i] = 1'b1;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/z80_bus_arbiter.md
# z80_bus_arbiter

Shares the Z80 system bus between the CPU and up to NREQ DMA-style requesters through the CPU's nBUSRQ/nBUSACK handshake. Sits beside z80_top_direct_n: drives its nBUSRQ input, samples its nBUSACK output, and hands a one-hot bus grant to one requester at a time.
- Round-robin fairness between requesters.
- Per-tenure hold limit.
- Guaranteed CPU gap between tenures so the CPU always makes progress.

## Interface
Parameters:
- NREQ, 2, number of requesters (1..8).
- MAX_HOLD, 256, maximum CLK cycles a requester may own the bus per tenure (≥1).
- CPU_GAP, 4, minimum CLK cycles the CPU owns the bus between tenures (0 allowed).

Ports:
- CLK  input  1  system clock, same clock as the Z80 core; all logic on rising edge.
- nRESET  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-requester bus request, level; held high for the whole tenure.
- grant  output  NREQ  one-hot grant; requester may drive A/D/control only while its bit is 1.
- bus_own  output  1  OR of grant; drives external bus-mux select.
- timeout  output  1  one-cycle pulse when a tenure is cut by MAX_HOLD.
- nBUSRQ  output  1  to the CPU, active low.
- nBUSACK  input  1  from the CPU, active low, synchronous to CLK (no synchronizer).

## Operation
- States: IDLE, REQUEST, GRANTED, RELEASE, GAP.
- IDLE: nBUSRQ=1, grant=0. If any req is high, go to REQUEST.
- REQUEST: nBUSRQ=0. Wait for nBUSACK=0.
  - On ack with any req high: pick the winner round-robin, starting at index (last+1) mod NREQ. Set grant to the winner, load the hold counter, go to GRANTED.
  - On ack with no req high (all dropped while waiting): go to RELEASE without granting.
- GRANTED: grant held stable; hold counter increments each cycle.
  - Winner's req falls: clear grant and go to RELEASE.
  - Counter reaches MAX_HOLD: clear grant, pulse timeout, go to RELEASE.
  - Requests from other requesters never preempt.
- RELEASE: nBUSRQ=1. Wait for nBUSACK=1.
  - Then go to GAP if CPU_GAP>0, else go to IDLE.
- GAP: count CPU_GAP cycles with nBUSRQ=1, then go to IDLE. New requests are ignored until IDLE.
- Round-robin pointer `last` updates only when a grant is issued. A timed-out requester therefore rotates to lowest priority.
- A requester that timed out and still holds req is treated as a fresh request after GAP.
- A req that rises and falls while nothing is waiting on it is simply missed. No latching.

## Timing
- Reset values: nBUSRQ=1, grant=0, bus_own=0, timeout=0, state=IDLE, last=NREQ-1 (so requester 0 wins first), counters=0.
- Reset asserted mid-tenure: all outputs return to reset values asynchronously. The CPU sees nBUSRQ rise immediately and ends its bus release.
- All outputs are registered.
- req sampled high at edge N in IDLE: nBUSRQ=0 after edge N.
- nBUSACK sampled low at edge M: grant valid after edge M (1-cycle latency).
- Winner req sampled low at edge K: grant=0 and nBUSRQ=1 after edge K.
- Timeout: if the grant becomes valid after edge M, it drops after edge M+MAX_HOLD, for exactly MAX_HOLD grant cycles. timeout is high for the cycle after that same edge.
- bus_own is never high while nBUSACK=1. grant is never asserted in any state except GRANTED.
- Hold counter width is clog2(MAX_HOLD+1). Gap counter width is clog2(CPU_GAP+1). Neither counter may wrap.

## Structure
- Package z80_bus_pkg holds:
  - state enum arb_state_t (IDLE, REQUEST, GRANTED, RELEASE, GAP);
  - default constants NREQ_DEF, MAX_HOLD_DEF, CPU_GAP_DEF.
- One sub-module: z80_rr_pick. Purely combinational.
  - Inputs: req vector, last index.
  - Outputs: one-hot pick and its index.
  - Reusable by a later interrupt-vector arbiter.
- The top holds the FSM, the counters and the output registers.

## Test plan
- Reset → nBUSRQ=1, grant=0, timeout=0. Pulse nRESET low while in GRANTED → all outputs return to reset values immediately.
- Single request: req=01, CPU model acks 3 cycles later → grant=01 one cycle after ack. Drop req → grant=00 and nBUSRQ=1 on the next edge. CPU model deasserts nBUSACK → 4 gap cycles, then IDLE.
- Round-robin: req=11 held continuously → grants alternate 01, 10, 01, with at least CPU_GAP cycles of nBUSRQ=1 between tenures.
- Timeout, with MAX_HOLD=8: req=01 held → grant lasts exactly 8 cycles, timeout pulses once, next tenure goes to requester 1 if it is requesting.
- Abandoned request: req=01 drops before nBUSACK falls → nBUSACK=0 arrives, no grant is issued, nBUSRQ rises the next cycle, and the arbiter waits for nBUSACK=1.
- Slow ack/release: nBUSACK held 20 cycles after nBUSRQ=0, and held low 10 cycles after release → the FSM waits in REQUEST/RELEASE with no spurious grant.
